// File: rtl/countdown_timer_param.sv
// Parametrised countdown timer: counts a latched period down to zero once per prescaled tick,
// with pause/resume, synchronous clear and one-shot or auto-reload operation.
`timescale 1ns/1ps

module countdown_timer_param #(
   parameter int WIDTH         = 4,
   parameter int TICKS_PER_SEC = 50_000_000
) (
   input  logic             clock,
   input  logic             reset,
   input  logic [WIDTH-1:0] period_i,
   input  logic             mode_i,
   input  logic             start_i,
   input  logic             pause_i,
   input  logic             clear_i,
   output logic [WIDTH-1:0] count_o,
   output logic             tick_o,
   output logic             finished_o,
   output logic             done_o,
   output logic             running_o,
   output logic             paused_o
);

   localparam int PW = (TICKS_PER_SEC > 1) ? $clog2(TICKS_PER_SEC) : 1;
   localparam logic [PW-1:0]    TERM = PW'(TICKS_PER_SEC - 1);
   localparam logic [WIDTH-1:0] ONE  = WIDTH'(1);

   typedef enum logic [1:0] {IDLE, RUN, PAUSED, DONE} state_t;

   state_t           state_q, state_d;
   logic [PW-1:0]    pre_q, pre_d;
   logic [WIDTH-1:0] period_q, period_d;
   logic             mode_q, mode_d;
   logic [WIDTH-1:0] count_d;
   logic             tick_d, finished_d;

   always_ff @(posedge clock) begin
      if (!reset) begin
         state_q    <= IDLE;
         pre_q      <= '0;
         period_q   <= '0;
         mode_q     <= 1'b0;
         count_o    <= '0;
         tick_o     <= 1'b0;
         finished_o <= 1'b0;
      end else begin
         state_q    <= state_d;
         pre_q      <= pre_d;
         period_q   <= period_d;
         mode_q     <= mode_d;
         count_o    <= count_d;
         tick_o     <= tick_d;
         finished_o <= finished_d;
      end
   end

   // Pulses default low; a zero count in RUN can only mean auto-reload, so it reloads.
   always_comb begin
      state_d    = state_q;
      pre_d      = pre_q;
      period_d   = period_q;
      mode_d     = mode_q;
      count_d    = count_o;
      tick_d     = 1'b0;
      finished_d = 1'b0;
      if (clear_i) begin
         state_d = IDLE;
         pre_d   = '0;
         count_d = period_i;
      end else begin
         case (state_q)
            IDLE, DONE: begin
               count_d = (state_q == IDLE) ? period_i : '0;
               if (start_i) begin
                  period_d = period_i;
                  mode_d   = mode_i;
                  pre_d    = '0;
                  if (period_i != '0) begin
                     state_d = RUN;
                     count_d = period_i;
                  end else begin
                     state_d    = DONE;
                     count_d    = '0;
                     finished_d = 1'b1;
                  end
               end
            end
            RUN: begin
               if (pause_i && !start_i) begin
                  state_d = PAUSED;
               end else if (pre_q == TERM) begin
                  pre_d  = '0;
                  tick_d = 1'b1;
                  if (count_o > ONE) begin
                     count_d = count_o - ONE;
                  end else if (count_o == ONE) begin
                     count_d    = '0;
                     finished_d = 1'b1;
                     if (!mode_q) state_d = DONE;
                  end else begin
                     count_d = period_q;
                  end
               end else begin
                  pre_d = pre_q + PW'(1);
               end
            end
            PAUSED: begin
               if (start_i) state_d = RUN;
            end
            default: state_d = IDLE;
         endcase
      end
   end

   assign running_o = (state_q == RUN);
   assign paused_o  = (state_q == PAUSED);
   assign done_o    = (state_q == DONE);

endmodule
